sq_wave_meas: RTL and testbench
===============================

SQ_WAVE_MEAS -- requirements
Module: sq_wave_meas

Interface
REQ-001 Parameter N SHALL be declared with default 4 and gives the width of the measured phase lengths.
REQ-002 Parameter TMO SHALL be declared with default 32 and gives the timeout in clock cycles of an unchanged level.
REQ-003 Port clk SHALL be an input, 1 bit wide: the single clock, with all state updated on its rising edge.
REQ-004 Port reset SHALL be an input, 1 bit wide: asynchronous, active-low reset.
REQ-005 Port sq_in SHALL be an input, 1 bit wide: the square wave under measurement, asynchronous to clk.
REQ-006 Port m_out SHALL be an output, N bits wide: the last measured high-phase length in clk cycles.
REQ-007 Port n_out SHALL be an output, N bits wide: the last measured low-phase length in clk cycles.
REQ-008 Port valid SHALL be an output, 1 bit wide: a one-cycle pulse when m_out and n_out update together.
REQ-009 Port ovf SHALL be an output, 1 bit wide: set when either phase of the last reported period exceeded 2^N-1 cycles.
REQ-010 Port timeout SHALL be an output, 1 bit wide: a level, high while no edge has been seen for TMO or more cycles.

Function
REQ-011 sq_in SHALL pass through a 2-flop synchronizer, followed by one delay flop for edge detection, giving signal s and rise/fall pulses.
REQ-012 The FSM SHALL have exactly three states: IDLE, HIGH and LOW.
REQ-013 From IDLE, the FSM SHALL go to HIGH on rise or to LOW on fall; no partial phase is ever measured.
REQ-014 In HIGH, a fall SHALL latch the high count into hi_reg and move the FSM to LOW.
REQ-015 In LOW, a rise SHALL move the FSM to HIGH; if hi_reg holds a phase measured since the last IDLE, the same rise SHALL load m_out and n_out and pulse valid.
REQ-016 The phase counter, N+1 bits wide, SHALL load 1 on the edge cycle and increment each following cycle, saturating at 2^(N+1)-1.
REQ-017 The reported length SHALL be min(count, 2^N-1); ovf SHALL be loaded with the valid pulse as the OR of each phase's saturation.
REQ-018 The length in cycles of a phase SHALL be the number of clk cycles on which s holds that level.
REQ-019 valid SHALL assert one cycle after the rise pulse, i.e. 4 clk edges after sq_in rises (2 synchronizer, 1 edge-detect, 1 register).
REQ-020 In HIGH or LOW, if no edge occurs within TMO cycles of the last edge, the FSM SHALL return to IDLE, timeout SHALL assert and m_out, n_out and ovf SHALL hold their values.
REQ-021 timeout SHALL clear on the next edge; that edge is handled as the first edge out of IDLE.
REQ-022 A glitch shorter than one clk period that the synchronizer does not capture SHALL produce no edge.
REQ-023 A one-cycle phase SHALL measure as 1; back-to-back one-cycle phases SHALL produce valid every 2 cycles.
REQ-024 Between valid pulses, m_out and n_out SHALL be stable.

Reset
REQ-025 While reset is low, all flops SHALL clear asynchronously: state IDLE, counters 0, m_out=0, n_out=0, valid=0, ovf=0, timeout=0.
REQ-026 Synchronizer flops SHALL reset to 0; the first high level of sq_in after reset is therefore a rise.
REQ-027 A reset asserted mid-measurement SHALL discard the partial period, and no valid SHALL follow the release of reset until a full high phase and a full low phase have been seen.

Structure
REQ-028 Package sq_meas_pkg SHALL hold the state enum (IDLE, HIGH, LOW) and the default constants for N and TMO.
REQ-029 One sub-module, sync_edge_det, SHALL implement the 2-flop synchronizer plus edge detector, with outputs s, rise and fall; all other logic SHALL be flat.

Verification
REQ-030 The bench SHALL drive sq_in as 5 cycles high then 3 cycles low, repeated, and require valid every 8 cycles with m_out=5, n_out=3 and ovf=0.
REQ-031 The bench SHALL drive 20 cycles high then 2 cycles low and require m_out=15, n_out=2 and ovf=1 on the valid pulse.
REQ-032 The bench SHALL hold sq_in low for 40 cycles after a valid period and require timeout=1 from cycle 32 after the last edge, m_out and n_out held, and no valid until two full phases follow.
REQ-033 The bench SHALL assert reset in the middle of the high phase of a 6/4 wave and require all outputs 0 immediately, with the first valid after release reporting only complete phases.
REQ-034 The bench SHALL drive 1 cycle high then 1 cycle low, repeated, and require m_out=1, n_out=1 with valid every 2 cycles.
REQ-035 The bench SHALL loop back a sq_wave_gen programmed with given M and N into this block and require m_out and n_out to match the generator's high and low phase lengths.

Source files
------------

// File: rtl/sq_meas_pkg.sv
// Shared types and default constants for the square-wave period measurement block.
package sq_meas_pkg;

  localparam int unsigned N_DEF   = 4;
  localparam int unsigned TMO_DEF = 32;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HIGH = 2'd1,
    LOW  = 2'd2
  } state_e;

endpackage

// File: rtl/sync_edge_det.sv
// Two-flop synchronizer for an asynchronous input, plus a registered edge-detect stage.
module sync_edge_det (
  input  logic clk,
  input  logic reset,
  input  logic sq_in,
  output logic s,
  output logic rise,
  output logic fall
);

  logic meta_q;
  logic sync_q;
  logic s_q;
  logic rise_q;
  logic fall_q;

  // s, rise and fall update together so the edge pulse coincides with the first cycle of the new level
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      meta_q <= 1'b0;
      sync_q <= 1'b0;
      s_q    <= 1'b0;
      rise_q <= 1'b0;
      fall_q <= 1'b0;
    end else begin
      meta_q <= sq_in;
      sync_q <= meta_q;
      s_q    <= sync_q;
      rise_q <= sync_q & ~s_q;
      fall_q <= ~sync_q & s_q;
    end
  end

  assign s    = s_q;
  assign rise = rise_q;
  assign fall = fall_q;

endmodule

// File: rtl/sq_wave_meas.sv
// Measures high and low phase lengths of an asynchronous square wave, with overflow and edge timeout.
module sq_wave_meas
  import sq_meas_pkg::*;
#(
  parameter int unsigned N   = N_DEF,
  parameter int unsigned TMO = TMO_DEF
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         sq_in,
  output logic [N-1:0] m_out,
  output logic [N-1:0] n_out,
  output logic         valid,
  output logic         ovf,
  output logic         timeout
);

  localparam int unsigned CW = N + 1;
  localparam int unsigned TW = $clog2(TMO + 1);
  localparam logic [CW-1:0] CNT_MAX  = '1;
  localparam logic [CW-1:0] LEN_MAX  = CW'((1 << N) - 1);
  localparam logic [TW-1:0] TMO_FULL = TW'(TMO);
  localparam logic [TW-1:0] TMO_LAST = TW'(TMO - 1);

  logic s;
  logic rise;
  logic fall;

  state_e         state_q, state_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic [TW-1:0]  tmo_q, tmo_d;
  logic [CW-1:0]  hi_q, hi_d;
  logic           hi_vld_q, hi_vld_d;
  logic [N-1:0]   m_q, m_d;
  logic [N-1:0]   n_q, n_d;
  logic           valid_q, valid_d;
  logic           ovf_q, ovf_d;
  logic           to_q, to_d;

  sync_edge_det u_sync (
    .clk   (clk),
    .reset (reset),
    .sq_in (sq_in),
    .s     (s),
    .rise  (rise),
    .fall  (fall)
  );

  function automatic logic [N-1:0] clip(input logic [CW-1:0] c);
    return (c > LEN_MAX) ? N'(LEN_MAX) : N'(c);
  endfunction

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      tmo_q    <= '0;
      hi_q     <= '0;
      hi_vld_q <= 1'b0;
      m_q      <= '0;
      n_q      <= '0;
      valid_q  <= 1'b0;
      ovf_q    <= 1'b0;
      to_q     <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      tmo_q    <= tmo_d;
      hi_q     <= hi_d;
      hi_vld_q <= hi_vld_d;
      m_q      <= m_d;
      n_q      <= n_d;
      valid_q  <= valid_d;
      ovf_q    <= ovf_d;
      to_q     <= to_d;
    end
  end

  // cnt_q/tmo_q equal the number of cycles s has held its level since the last edge
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    tmo_d    = tmo_q;
    hi_d     = hi_q;
    hi_vld_d = hi_vld_q;
    m_d      = m_q;
    n_d      = n_q;
    valid_d  = 1'b0;
    ovf_d    = ovf_q;
    to_d     = to_q;

    if (rise || fall) begin
      cnt_d = CW'(1);
      tmo_d = TW'(1);
    end else begin
      if (cnt_q != CNT_MAX)  cnt_d = cnt_q + CW'(1);
      if (tmo_q != TMO_FULL) tmo_d = tmo_q + TW'(1);
    end

    case (state_q)
      IDLE: begin
        if (rise || fall) begin
          state_d  = rise ? HIGH : LOW;
          to_d     = 1'b0;
          hi_vld_d = 1'b0;
        end
      end
      HIGH: begin
        if (fall) begin
          hi_d     = cnt_q;
          hi_vld_d = 1'b1;
          state_d  = LOW;
        end else if (tmo_q == TMO_LAST) begin
          state_d  = IDLE;
          to_d     = 1'b1;
          hi_vld_d = 1'b0;
        end
      end
      LOW: begin
        if (rise) begin
          state_d = HIGH;
          if (hi_vld_q) begin
            m_d     = clip(hi_q);
            n_d     = clip(cnt_q);
            ovf_d   = (hi_q > LEN_MAX) | (cnt_q > LEN_MAX);
            valid_d = 1'b1;
          end
        end else if (tmo_q == TMO_LAST) begin
          state_d  = IDLE;
          to_d     = 1'b1;
          hi_vld_d = 1'b0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign m_out   = m_q;
  assign n_out   = n_q;
  assign valid   = valid_q;
  assign ovf     = ovf_q;
  assign timeout = to_q;

endmodule

// File: tb/tb_sq_wave_meas.sv
// Bench for sq_wave_meas: per-cycle reference model plus table-driven and hand-written scenarios.
module tb_sq_wave_meas;

  localparam int NW   = 4;
  localparam int TMO  = 32;
  localparam int LMAX = 15;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          sq_in = 1'b0;
  logic [NW-1:0] m_out;
  logic [NW-1:0] n_out;
  logic          valid;
  logic          ovf;
  logic          timeout;

  sq_wave_meas #(.N(NW), .TMO(TMO)) dut (
    .clk     (clk),
    .reset   (reset),
    .sq_in   (sq_in),
    .m_out   (m_out),
    .n_out   (n_out),
    .valid   (valid),
    .ovf     (ovf),
    .timeout (timeout)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, got, exp, $time);
    end
  endtask

  // Reference model: s lags the sampled sq_in by three cycles; phases are runs of equal s.
  bit pipe [3];
  bit prev_s, in_run, have_hi;
  int run_len, hi_len;
  int e_m, e_n;
  bit e_valid, e_ovf, e_to;

  function int clamp(input int x);
    return (x > LMAX) ? LMAX : x;
  endfunction

  function void model_reset();
    for (int i = 0; i < 3; i++) pipe[i] = 1'b0;
    prev_s = 0; in_run = 0; have_hi = 0;
    run_len = 0; hi_len = 0;
    e_m = 0; e_n = 0; e_valid = 0; e_ovf = 0; e_to = 0;
  endfunction

  function void model_step(input bit s);
    e_valid = 0;
    if (s != prev_s) begin
      if (in_run) begin
        if (prev_s) begin
          hi_len  = run_len;
          have_hi = 1;
        end else if (have_hi) begin
          e_m     = clamp(hi_len);
          e_n     = clamp(run_len);
          e_ovf   = (hi_len > LMAX) || (run_len > LMAX);
          e_valid = 1;
        end
      end else begin
        have_hi = 0;
      end
      in_run  = 1;
      run_len = 1;
      e_to    = 0;
    end else if (in_run) begin
      run_len++;
      if (run_len >= TMO) begin
        in_run  = 0;
        have_hi = 0;
        e_to    = 1;
      end
    end
    prev_s = s;
  endfunction

  int cyc = 0;
  int v_count = 0;
  int last_v_cyc = 0;
  int last_int = 0;
  int lv_m = 0, lv_n = 0, lv_ovf = 0;

  always @(negedge clk) begin
    cyc++;
    if (!reset) begin
      check("rst_m", m_out, 0);
      check("rst_n", n_out, 0);
      check("rst_valid", valid, 0);
      check("rst_ovf", ovf, 0);
      check("rst_timeout", timeout, 0);
      model_reset();
    end else begin
      check("mdl_valid", valid, e_valid);
      check("mdl_m", m_out, e_m);
      check("mdl_n", n_out, e_n);
      check("mdl_ovf", ovf, e_ovf);
      check("mdl_timeout", timeout, e_to);
      if (valid === 1'b1) begin
        last_int   = cyc - last_v_cyc;
        last_v_cyc = cyc;
        v_count++;
        lv_m   = m_out;
        lv_n   = n_out;
        lv_ovf = ovf;
      end
      model_step(pipe[2]);
      pipe[2] = pipe[1];
      pipe[1] = pipe[0];
      pipe[0] = sq_in;
    end
  end

  // Drive a level for n cycles; always entered and left 1 time unit after a rising edge.
  task automatic drive(input bit lvl, input int n);
    sq_in = lvl;
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic wave(input int h, input int l, input int reps);
    repeat (reps) begin
      drive(1'b1, h);
      drive(1'b0, l);
    end
  endtask

  typedef struct {
    int hi;
    int lo;
    int reps;
    int em;
    int en;
    int eovf;
  } vec_t;

  vec_t vt [7];

  initial begin
    int v0;
    int len;
    bit lvl;

    vt[0] = '{hi: 5,  lo: 3,  reps: 4, em: 5,  en: 3,  eovf: 0};
    vt[1] = '{hi: 20, lo: 2,  reps: 3, em: 15, en: 2,  eovf: 1};
    vt[2] = '{hi: 1,  lo: 1,  reps: 8, em: 1,  en: 1,  eovf: 0};
    vt[3] = '{hi: 2,  lo: 9,  reps: 3, em: 2,  en: 9,  eovf: 0};
    vt[4] = '{hi: 15, lo: 16, reps: 3, em: 15, en: 15, eovf: 1};
    vt[5] = '{hi: 16, lo: 15, reps: 3, em: 15, en: 15, eovf: 1};
    vt[6] = '{hi: 1,  lo: 15, reps: 3, em: 1,  en: 15, eovf: 0};

    reset = 1'b0;
    sq_in = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b1;
    drive(1'b0, 4);

    // Periodic waves; the trailing rise makes the last full period report.
    for (int i = 0; i < 7; i++) begin
      v0 = v_count;
      wave(vt[i].hi, vt[i].lo, vt[i].reps);
      drive(1'b1, 5);
      check("tbl_m", lv_m, vt[i].em);
      check("tbl_n", lv_n, vt[i].en);
      check("tbl_ovf", lv_ovf, vt[i].eovf);
      check("tbl_period", last_int, vt[i].hi + vt[i].lo);
      check("tbl_vcount", 32'(v_count - v0 >= vt[i].reps), 1);
      drive(1'b0, 3);
    end

    // Timeout after a long low, with an uncaptured glitch in the middle.
    wave(5, 3, 3);
    drive(1'b1, 5);
    v0 = v_count;
    sq_in = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      check("tmo_level", timeout, 32'(i >= 35));
      if (i == 10) begin
        #1 sq_in = 1'b1;
        #2 sq_in = 1'b0;
      end
    end
    @(posedge clk);
    #1;
    check("tmo_novalid", v_count - v0, 0);
    check("tmo_hold_m", m_out, 5);
    check("tmo_hold_n", n_out, 3);
    check("tmo_hold_ovf", ovf, 0);
    drive(1'b1, 5);
    check("tmo_clear", timeout, 0);
    drive(1'b0, 3);
    check("tmo_wait_two", v_count - v0, 0);
    drive(1'b1, 5);
    check("tmo_resume_cnt", v_count - v0, 1);
    check("tmo_resume_m", lv_m, 5);
    check("tmo_resume_n", lv_n, 3);
    drive(1'b0, 3);

    // Reset in the middle of the high phase of a 6/4 wave.
    wave(6, 4, 3);
    drive(1'b1, 3);
    reset = 1'b0;
    @(negedge clk);
    check("rmid_m", m_out, 0);
    check("rmid_n", n_out, 0);
    check("rmid_valid", valid, 0);
    check("rmid_ovf", ovf, 0);
    check("rmid_timeout", timeout, 0);
    @(posedge clk);
    #1;
    drive(1'b1, 2);
    drive(1'b0, 1);
    reset = 1'b1;
    drive(1'b0, 3);
    v0 = v_count;
    wave(6, 4, 1);
    check("rrel_novalid", v_count - v0, 0);
    drive(1'b1, 5);
    check("rrel_cnt", v_count - v0, 1);
    check("rrel_m", lv_m, 6);
    check("rrel_n", lv_n, 4);
    check("rrel_ovf", lv_ovf, 0);
    drive(1'b0, 3);

    // Loop back a generator programmed with random M/N.
    for (int r = 0; r < 6; r++) begin
      int gm;
      int gn;
      gm = $urandom_range(1, 15);
      gn = $urandom_range(1, 15);
      wave(gm, gn, 3);
      drive(1'b1, 5);
      check("gen_m", lv_m, gm);
      check("gen_n", lv_n, gn);
      check("gen_ovf", lv_ovf, 0);
      drive(1'b0, 3);
    end

    // Random run lengths, including timeouts and overflows; the model checks every cycle.
    lvl = 1'b1;
    for (int k = 0; k < 300; k++) begin
      len = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 40) : $urandom_range(1, 8);
      drive(lvl, len);
      lvl = ~lvl;
    end

    drive(1'b0, 10);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
